// File: rtl/pipe_stage_hs_pkg.sv
// Shared types and constants for the valid/ready pipeline stage register.
// Phase wrappers pick their bundle width and NOP pattern from here.
package pipe_stage_hs_pkg;

  // Stage state doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL1 = 2'd1,
    ST_FULL2 = 2'd2
  } stage_state_e;

  localparam int unsigned OCC_W = 2;

  // Per-phase control bundle widths and their NOP bubble patterns.
  localparam int unsigned PH1_CTL_W = 16;
  localparam int unsigned PH2_CTL_W = 24;
  localparam int unsigned PH3_CTL_W = 16;
  localparam logic [PH1_CTL_W-1:0] PH1_NOP = 16'h0000;
  localparam logic [PH2_CTL_W-1:0] PH2_NOP = 24'h000000;
  localparam logic [PH3_CTL_W-1:0] PH3_NOP = 16'h0000;

  function automatic logic [OCC_W-1:0] occ_of(input stage_state_e st);
    return OCC_W'(st);
  endfunction

endpackage

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage register with flush and an optional 2-entry skid.
// SKID=1 registers in_ready; SKID=0 is a single register with combinational in_ready.
module pipe_stage_hs
  import pipe_stage_hs_pkg::*;
#(
  parameter int unsigned        DATA_W = 16,
  parameter logic [DATA_W-1:0]  BUBBLE = '0,
  parameter bit                 SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // State and head-entry registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  // Next state: flush overrides any handshake but an out transfer still counts as consumed.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_d  = in_data;
          state_d = ST_FULL1;
        end
      end
      ST_FULL1: begin
        if (out_xfer && in_xfer) begin
          main_d = in_data;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end else if (in_xfer && SKID) begin
          skid_d  = in_data;
          state_d = ST_FULL2;
        end
      end
      ST_FULL2: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ST_FULL1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  // Outputs: the head is only exposed while live, otherwise the NOP pattern.
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    out_data  = out_valid ? main_q : BUBBLE;
    occupancy = occ_of(state_q);
  end

  if (SKID) begin : g_skid
    logic in_ready_q;

    // Skid content is never visible while empty, so it needs no reset.
    always_ff @(posedge clk) begin
      skid_q <= skid_d;
    end

    // in_ready looks only at the next state, keeping out_ready off the upstream path.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        in_ready_q <= 1'b1;
      end else begin
        in_ready_q <= (state_d != ST_FULL2);
      end
    end

    assign in_ready = in_ready_q;
  end else begin : g_no_skid
    logic unused_skid;

    assign skid_q      = main_q;
    assign unused_skid = ^skid_d;
    assign in_ready    = !out_valid | out_ready;
  end

endmodule
